// File: rtl/vga_timing_gen_if.sv
// Control inputs and raster/sync/tick outputs of vga_timing_gen.
// The generator drives through the master modport; draw logic observes through slave.
interface vga_timing_gen_if #(
  parameter int HW     = 11,
  parameter int VW     = 10,
  parameter int TDIV_W = 8
);
  logic              frz;
  logic [TDIV_W-1:0] tick_div;
  logic              pix_en;
  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
  logic              game_tick;

  modport master (
    input  frz, tick_div,
    output pix_en, hcount, vcount, de, hsync, vsync, frame_start, game_tick
  );

  modport slave (
    output frz, tick_div,
    input  pix_en, hcount, vcount, de, hsync, vsync, frame_start, game_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-rate divider, h/v counters, sync/DE
// decode through a PIPE_LAT-pixel delay line, and a frame-based game tick with freeze.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_LAT = 1,
  parameter int TDIV_W   = 8
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0]       div_q, div_d;
  logic                pix_en_q, pix_en_d;
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [PIPE_LAT-1:0] de_pipe_q, de_pipe_d;
  logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic                frame_start_q, frame_start_d;
  logic                game_tick_q, game_tick_d;
  logic [TDIV_W-1:0]   fcnt_q, fcnt_d;

  logic                active, hs_raw, vs_raw, h_wrap, raster_wrap;
  logic [TDIV_W-1:0]   eff;
  logic [TDIV_W:0]     fcnt_inc;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_q == DIV_LAST);

    active      = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw      = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vs_raw      = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    h_wrap      = (h_q == H_LAST);
    raster_wrap = pix_en_q && h_wrap && (v_q == V_LAST);

    h_d       = h_q;
    v_d       = v_q;
    de_pipe_d = de_pipe_q;
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;
    // Decode uses the pre-advance counters so stage 0 lags hcount by one pixel.
    if (pix_en_q) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      de_pipe_d = (de_pipe_q << 1) | PIPE_LAT'(active);
      hs_pipe_d = (hs_pipe_q << 1) | PIPE_LAT'(hs_raw);
      vs_pipe_d = (vs_pipe_q << 1) | PIPE_LAT'(vs_raw);
    end

    eff           = (bus.tick_div == '0) ? TDIV_W'(1) : bus.tick_div;
    fcnt_inc      = {1'b0, fcnt_q} + 1'b1;
    fcnt_d        = fcnt_q;
    game_tick_d   = 1'b0;
    frame_start_d = raster_wrap;
    // The >= compare lets a lowered tick_div fire at the very next frame.
    if (raster_wrap && !bus.frz) begin
      if (fcnt_inc >= {1'b0, eff}) begin
        game_tick_d = 1'b1;
        fcnt_d      = '0;
      end else begin
        fcnt_d = fcnt_inc[TDIV_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      frame_start_q <= 1'b0;
      game_tick_q   <= 1'b0;
      fcnt_q        <= '0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      h_q           <= h_d;
      v_q           <= v_d;
      de_pipe_q     <= de_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      frame_start_q <= frame_start_d;
      game_tick_q   <= game_tick_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign bus.pix_en      = pix_en_q;
  assign bus.hcount      = h_q;
  assign bus.vcount      = v_q;
  assign bus.de          = de_pipe_q[PIPE_LAT-1];
  assign bus.hsync       = hs_pipe_q[PIPE_LAT-1] ? HS_POL : ~HS_POL;
  assign bus.vsync       = vs_pipe_q[PIPE_LAT-1] ? VS_POL : ~VS_POL;
  assign bus.frame_start = frame_start_q;
  assign bus.game_tick   = game_tick_q;
endmodule
